// File: rtl/skid_pkg.sv
// rtl/skid_pkg.sv - shared handshake-stage state encoding and helpers
// Used by skid_buf and by any bench scoreboard that tracks its occupancy.
package skid_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  localparam int unsigned SKID_DEPTH = 2;

  // Occupancy is the state encoding itself; the illegal code maps to empty.
  function automatic logic [1:0] state_occ(input skid_state_e st);
    logic [1:0] occ_v;
    case (st)
      ST_EMPTY: occ_v = 2'd0;
      ST_BUSY:  occ_v = 2'd1;
      ST_FULL:  occ_v = 2'd2;
      default:  occ_v = 2'd0;
    endcase
    return occ_v;
  endfunction

endpackage

// File: rtl/skid_buf_dff.sv
// rtl/skid_buf_dff.sv - plain DW-wide data flop with no reset
// Load/hold and reset-to-zero selection live in the caller's mux path.
module skid_buf_dff #(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);

  logic [DW-1:0] data_q;

  always_ff @(posedge clk_i) begin
    data_q <= d_i;
  end

  assign q_o = data_q;

endmodule

// File: rtl/skid_buf.sv
// rtl/skid_buf.sv - two-entry valid/ready register slice
// All outputs come straight from flops; the skid entry absorbs one word of backpressure.
module skid_buf
  import skid_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [1:0]    occ
);

  skid_state_e   state_q, state_d;
  logic          s_ready_q, s_ready_d;
  logic          m_valid_q, m_valid_d;
  logic [1:0]    occ_q, occ_d;
  logic          clr_pend_q;

  logic          xfer_in, xfer_out;
  logic          load_out, out_from_skid, load_skid;
  logic [DW-1:0] out_d, out_q;
  logic [DW-1:0] skid_d, skid_q;

  assign xfer_in  = s_valid & s_ready_q;
  assign xfer_out = m_valid_q & m_ready;

  // State and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      s_ready_q  <= 1'b1;
      m_valid_q  <= 1'b0;
      occ_q      <= 2'd0;
      clr_pend_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      s_ready_q  <= s_ready_d;
      m_valid_q  <= m_valid_d;
      occ_q      <= occ_d;
      clr_pend_q <= 1'b0;
    end
  end

  always_comb begin
    state_d       = state_q;
    load_out      = 1'b0;
    out_from_skid = 1'b0;
    load_skid     = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (xfer_in) begin
            state_d  = ST_BUSY;
            load_out = 1'b1;
          end
        end
        ST_BUSY: begin
          if (xfer_in && xfer_out) begin
            load_out = 1'b1;
          end else if (xfer_in) begin
            state_d   = ST_FULL;
            load_skid = 1'b1;
          end else if (xfer_out) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (xfer_out) begin
            state_d       = ST_BUSY;
            load_out      = 1'b1;
            out_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    m_valid_d = (state_d != ST_EMPTY);
    s_ready_d = (state_d != ST_FULL);
    occ_d     = state_occ(state_d);
  end

  // Data regs carry no reset; the first cycle out of reset zeroes any entry not being loaded.
  always_comb begin
    if (load_out)
      out_d = out_from_skid ? skid_q : s_data;
    else if (clr_pend_q)
      out_d = '0;
    else
      out_d = out_q;

    if (load_skid)
      skid_d = s_data;
    else if (clr_pend_q)
      skid_d = '0;
    else
      skid_d = skid_q;
  end

  skid_buf_dff #(.DW(DW)) u_out_reg (
    .clk_i (clk),
    .d_i   (out_d),
    .q_o   (out_q)
  );

  skid_buf_dff #(.DW(DW)) u_skid_reg (
    .clk_i (clk),
    .d_i   (skid_d),
    .q_o   (skid_q)
  );

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign occ     = occ_q;
  assign m_data  = out_q;

endmodule

// File: tb/tb_skid_buf.sv
// tb/tb_skid_buf.sv - self-checking bench for skid_buf
// Directed table, hand sequences and a queue-model random run.
module tb_skid_buf;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [1:0]  occ;

  int passed;
  int total;

  skid_buf #(.DW(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .occ     (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sv;
    logic [31:0] sd;
    logic        mr;
    logic        fl;
    logic        emv;
    logic        esr;
    logic [1:0]  eocc;
    logic [31:0] emd;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] q[$];
    logic        in_x, out_x;
    bit          ok;

    passed = 0;
    total  = 0;
    rst_n   = 1'b0;
    flush   = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'hA5A5_A5A5;
    m_ready = 1'b0;

    // Reset held with upstream valid: nothing accepted, nothing emitted.
    repeat (3) step();
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_occ",     32'(occ),     32'd0);
    s_valid = 1'b0;
    rst_n   = 1'b1;
    step();
    check("post_rst_m_data", m_data, 32'd0);
    check("post_rst_occ",    32'(occ), 32'd0);

    // Back-to-back throughput with m_ready held.
    m_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      s_valid = 1'b1;
      s_data  = 32'(k);
      step();
      check($sformatf("tput_data_%0d", k), m_data, 32'(k));
      check($sformatf("tput_valid_%0d", k), 32'(m_valid), 32'd1);
      check($sformatf("tput_ready_%0d", k), 32'(s_ready), 32'd1);
      check($sformatf("tput_occ_%0d", k), 32'(occ), 32'd1);
    end
    s_valid = 1'b0;
    step();
    check("tput_drain_valid", 32'(m_valid), 32'd0);
    check("tput_drain_occ",   32'(occ),     32'd0);

    // Backpressure fill/drain, then flush from FULL.
    vecs[0] = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'h11};
    vecs[1] = '{1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'h11};
    vecs[2] = '{1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'h11};
    vecs[3] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'h22};
    vecs[4] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h22};
    vecs[5] = '{1'b1, 32'h44, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'h44};
    vecs[6] = '{1'b1, 32'h55, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'h44};
    vecs[7] = '{1'b1, 32'h66, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 32'h44};
    vecs[8] = '{1'b1, 32'h77, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'h77};
    vecs[9] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h77};
    for (int i = 0; i < 10; i++) begin
      s_valid = vecs[i].sv;
      s_data  = vecs[i].sd;
      m_ready = vecs[i].mr;
      flush   = vecs[i].fl;
      step();
      check($sformatf("vec%0d_m_valid", i), 32'(m_valid), 32'(vecs[i].emv));
      check($sformatf("vec%0d_s_ready", i), 32'(s_ready), 32'(vecs[i].esr));
      check($sformatf("vec%0d_occ", i),     32'(occ),     32'(vecs[i].eocc));
      check($sformatf("vec%0d_m_data", i),  m_data,       vecs[i].emd);
    end
    flush = 1'b0;

    // Random traffic against a two-slot FIFO model.
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      s_valid = ($urandom_range(0, 1) == 1);
      s_data  = $urandom;
      m_ready = ($urandom_range(0, 1) == 1);
      in_x  = s_valid && (q.size() < 2);
      out_x = m_ready && (q.size() > 0);
      if (out_x) void'(q.pop_front());
      if (in_x) q.push_back(s_data);
      step();
      ok = (m_valid == (q.size() > 0)) && (s_ready == (q.size() < 2)) &&
           (32'(occ) == 32'(q.size())) && ((q.size() == 0) || (m_data == q[0]));
      total++;
      if (ok) passed++;
      else $display("FAIL rand_cyc%0d: got v=%0b r=%0b occ=%0d d=%0h want occ=%0d d=%0h",
                    c, m_valid, s_ready, occ, m_data, q.size(),
                    (q.size() > 0) ? q[0] : 32'd0);
    end

    // Asynchronous reset while FULL, then clean restart.
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (3) step();
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'hAAAA_0001;
    step();
    s_data  = 32'hAAAA_0002;
    step();
    check("full_occ", 32'(occ), 32'd2);
    s_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("async_m_valid", 32'(m_valid), 32'd0);
    check("async_occ",     32'(occ),     32'd0);
    check("async_s_ready", 32'(s_ready), 32'd1);
    step();
    rst_n = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'hC0DE_0003;
    m_ready = 1'b1;
    step();
    check("restart_data",  m_data,        32'hC0DE_0003);
    check("restart_valid", 32'(m_valid),  32'd1);
    s_valid = 1'b0;
    step();
    check("restart_drain", 32'(m_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
